apb_cmd_master: RTL and testbench

// - APB3 initiator (requester) driving the transceiver's APB register slave from a simple command/response port.
// - Sits between a host/test sequencer and the register block (control, Tx data, Rx data, flags).
// - Converts one command into one APB SETUP/ACCESS transfer and returns read data and status.
// - Handles wait states (pready), slave errors (pslverr), misaligned addresses and an optional watchdog.

---
 rtl/apb_cmd_master.sv | 148 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB3 requester turning one command into one SETUP/ACCESS transfer; watchdog enabled by APB_CMD_TIMEOUT_EN
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("apb_cmd_master: TIMEOUT must be >= 1");
    end

    state_t            state_q, state_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

`ifdef APB_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Watchdog counter of consecutive wait states in ACCESS.
    always_ff @(posedge pclk or negedge preset)
        if (!preset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
`endif

    // Next-state and registered-output logic; every register holds unless a transition changes it.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_CMD_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                pwrite_d = cmd_write_i;
                paddr_d  = cmd_addr_i;
                pwdata_d = cmd_wdata_i;
                if (cmd_addr_i[1:0] == 2'b00) begin
                    state_d = SETUP;
                    psel_d  = 1'b1;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_CMD_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_i;
                    rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                end
`ifdef APB_CMD_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RESP: if (rsp_ready_i) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge pclk or negedge preset)
        if (!preset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end

    assign cmd_ready_o = (state_q == IDLE);
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed table plus hand sequences for apb_cmd_master; covers APB_CMD_TIMEOUT_EN when defined
module tb_apb_cmd_master;
    logic        pclk = 1'b0, preset = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0, rsp_ready_i = 1'b0;
    logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0, prdata_i = '0;
    logic        pready_i = 1'b1, pslverr_i = 1'b0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, psel_o, penable_o, pwrite_o;
    logic [31:0] rsp_rdata_o, paddr_o, pwdata_o;
    int          checks = 0, errors = 0;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr, wdata, prdata;
        logic        slverr;
        int          waits;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic run(input vec_t v);
        bit mis = (v.addr[1:0] != 2'b00);
        int n   = 0;
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_write_i = v.wr; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata;
        rsp_ready_i = 1'b1; pready_i = (v.waits == 0); prdata_i = v.prdata; pslverr_i = v.slverr;
        step();
        cmd_valid_i = 1'b0;
        chk("paddr", paddr_o, v.addr);
        chk("pwrite", pwrite_o, v.wr);
        chk("pwdata", pwdata_o, v.wdata);
        chk("cmd_ready_busy", cmd_ready_o, 0);
        if (mis) begin
            chk("psel_mis", psel_o, 0);
            while (!rsp_valid_o && n < 2) begin
                step();
                chk("psel_mis_wait", psel_o, 0);
                n++;
            end
        end else begin
            chk("psel_setup", psel_o, 1);
            chk("penable_setup", penable_o, 0);
            step();
            chk("psel_access", psel_o, 1);
            chk("penable_access", penable_o, 1);
            for (int i = 0; i < v.waits; i++) begin
                step();
                chk("hold_penable", penable_o, 1);
                chk("hold_psel", psel_o, 1);
                chk("hold_paddr", paddr_o, v.addr);
                chk("hold_pwdata", pwdata_o, v.wdata);
                chk("hold_no_rsp", rsp_valid_o, 0);
            end
            pready_i = 1'b1;
            step();
            chk("psel_done", psel_o, 0);
            chk("penable_done", penable_o, 0);
        end
        chk("rsp_valid", rsp_valid_o, 1);
        chk("rsp_err", rsp_err_o, v.exp_err);
        chk("rsp_rdata", rsp_rdata_o, v.exp_rdata);
        chk("cmd_ready_resp", cmd_ready_o, 0);
        step();
        chk("rsp_valid_clear", rsp_valid_o, 0);
        chk("cmd_ready_back", cmd_ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 1'b0, 3, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'h0000_000C, 32'h0,         32'hFFFF_FFFF, 1'b1, 0, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0006, 32'h0,         32'h1111_2222, 1'b0, 0, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 32'h3333_4444, 1'b1, 1, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 32'h0000_0003, 32'h5555_AAAA, 32'h0,         1'b0, 0, 1'b1, 32'h0};

        repeat (2) step();
        chk("rst_psel", psel_o, 0);
        chk("rst_penable", penable_o, 0);
        chk("rst_pwrite", pwrite_o, 0);
        chk("rst_paddr", paddr_o, 0);
        chk("rst_pwdata", pwdata_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        preset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run(vecs[i]);

        // response backpressure with a competing command pending
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h14; rsp_ready_i = 1'b0;
        pready_i = 1'b1; prdata_i = 32'h55AA_33CC; pslverr_i = 1'b0;
        step();
        cmd_write_i = 1'b1; cmd_addr_i = 32'h18; cmd_wdata_i = 32'h0000_0077;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid_o, 1);
            chk("bp_rsp_rdata", rsp_rdata_o, 32'h55AA_33CC);
            chk("bp_rsp_err", rsp_err_o, 0);
            chk("bp_cmd_ready", cmd_ready_o, 0);
            chk("bp_psel", psel_o, 0);
            chk("bp_paddr", paddr_o, 32'h14);
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        chk("bp_handshake", rsp_valid_o, 0);
        chk("bp_idle_ready", cmd_ready_o, 1);
        chk("bp_idle_psel", psel_o, 0);
        step();
        cmd_valid_i = 1'b0;
        chk("bp_next_psel", psel_o, 1);
        chk("bp_next_paddr", paddr_o, 32'h18);
        chk("bp_next_pwrite", pwrite_o, 1);
        step();
        step();
        chk("bp_next_rsp", rsp_valid_o, 1);
        chk("bp_next_rdata", rsp_rdata_o, 0);
        step();

        // slave never ready
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h20; pready_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        step();
`ifdef APB_CMD_TIMEOUT_EN
        n = 0;
        while (!rsp_valid_o && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_err", rsp_err_o, 1);
        chk("timeout_rdata", rsp_rdata_o, 0);
        chk("timeout_psel", psel_o, 0);
        step();
        cmd_valid_i = 1'b1; cmd_addr_i = 32'h24;
        step();
        cmd_valid_i = 1'b0;
        step();
`else
        n = 0;
        repeat (100) begin
            step();
            n++;
        end
        chk("no_timeout_psel", psel_o, 1);
        chk("no_timeout_penable", penable_o, 1);
        chk("no_timeout_rsp", rsp_valid_o, 0);
`endif
        // asynchronous reset while stuck in ACCESS
        #2 preset = 1'b0;
        #1;
        chk("arst_psel", psel_o, 0);
        chk("arst_penable", penable_o, 0);
        chk("arst_rsp_valid", rsp_valid_o, 0);
        chk("arst_paddr", paddr_o, 0);
        @(negedge pclk);
        preset = 1'b1;
        pready_i = 1'b1;
        step();
        run(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
